pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Owns the program counter and drives the instruction-memory fetch handshake for the 16-bit RISC core. Each cycle it chooses the next PC from four sources: sequential +1 (PC adder), branch/jump redirect, halt hold, or an optional return-address stack. It holds the fetch address stable across memory wait states, squashes fetches made stale by redirects, and reports accepted instructions to decode.

Parameters:
AW, 8, PC/address width in bits
RESET_PC, 8'h00, PC value loaded on reset
RAS_DEPTH, 4, return-stack entries (used only with PC_RAS_EN; power of 2, at least 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  decode back-pressure; while high, no new fetch request is issued
imem_req_o  output  1  fetch request to instruction memory
imem_ack_i  input  1  memory accepts the request this cycle
pc_o  output  AW  current fetch address, valid while imem_req_o=1
redirect_i  input  1  single-cycle pulse: branch/jump taken
redirect_tgt_i  input  AW  target address, sampled with redirect_i
halt_i  input  1  single-cycle pulse: stop fetching
resume_i  input  1  leave HALTED
fetch_valid_o  output  1  pulse: an instruction was accepted and not squashed
fetch_pc_o  output  AW  address of the instruction flagged by fetch_valid_o
halted_o  output  1  high in the HALTED state
call_i  input  1  call marker; accompanies redirect_i (active with PC_RAS_EN)
call_link_i  input  AW  return address to push (active with PC_RAS_EN)
ret_i  input  1  return pulse: redirect to the stack top (active with PC_RAS_EN)
ras_err_o  output  1  sticky stack underflow/overflow flag (active with PC_RAS_EN)

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, pc_o=RESET_PC, imem_req_o=0, fetch_valid_o=0, fetch_pc_o=0, halted_o=0, pending redirect cleared, stack empty, ras_err_o=0.
- State BOOT: lasts 1 cycle after reset release, then goes to FETCH.
- State FETCH:
  - imem_req_o = ~stall_i, except a request already raised stays high until accepted.
  - Accept occurs when imem_req_o & imem_ack_i.
  - Once raised, pc_o must not change until accept. Stall cannot drop an outstanding request.
- Accept with no redirect pending or arriving:
  - Next cycle: fetch_valid_o=1, fetch_pc_o = accepted pc_o.
  - pc_o <= pc_o+1, truncated to AW bits. 0xFF wraps to 0x00 with no flag.
  - Back-to-back accepts are allowed: 1 instruction per cycle.
- Next-PC priority, highest first: redirect_i, then ret_i, then halt_i, then sequential.
- Redirect with no outstanding request: pc_o <= redirect_tgt_i next cycle.
- Redirect while a request is outstanding:
  - Target is latched as pending.
  - The instruction accepted under that request is squashed (fetch_valid_o stays 0).
  - pc_o <= pending target on accept.
- Redirect in the same cycle as accept: the accepted instruction is squashed and pc_o <= redirect_tgt_i.
- A second redirect while one is pending overwrites the pending target.
- halt_i with no outstanding request: go to HALTED next cycle.
- halt_i with an outstanding request: the fetch completes and is delivered normally; HALTED is entered after accept.
- HALTED: imem_req_o=0, halted_o=1, pc_o holds the next sequential or redirected PC. resume_i returns to FETCH next cycle. redirect_i in HALTED updates pc_o but stays HALTED.
- fetch_valid_o is a one-cycle pulse. It is never asserted in BOOT or HALTED, except for the delivery of a completed pre-halt fetch.
- Reset asserted mid-request: imem_req_o drops immediately. Memory must tolerate an abandoned request on reset only.

Optional Feature:
PC_RAS_EN
- Defined: RAS_DEPTH-entry LIFO return stack.
  - call_i&redirect_i pushes call_link_i.
  - ret_i redirects to the stack top and pops it. It follows the same pending/squash rules as redirect.
  - Overflow drops the oldest entry and sets ras_err_o.
  - ret_i on an empty stack redirects to RESET_PC and sets ras_err_o.
  - ras_err_o clears only on reset.
- Undefined: no stack storage. call_i, call_link_i and ret_i are ignored; ras_err_o is tied to 0.

Test Plan:
- Reset release, ack always 1 -> BOOT 1 cycle; pc_o sequence 00,01,02,...; fetch_valid_o high every cycle from the 3rd cycle, fetch_pc_o lagging pc_o by 1.
- Start at pc_o=0xFE, continuous ack -> fetch_pc_o 0xFE,0xFF,0x00,0x01 (wrap).
- pc_o=0x10, req high, ack low 3 cycles, stall_i toggling -> pc_o stays 0x10 and req stays high; on ack, fetch_pc_o=0x10 and the next pc_o=0x11.
- Outstanding req at 0x20, redirect_i with tgt=0x80 while ack=0, ack 2 cycles later -> no fetch_valid_o for 0x20; next pc_o=0x80.
- halt_i while idle at pc 0x33 -> halted_o=1 and req=0 for 5 cycles; resume_i -> fetch resumes at 0x33.
- PC_RAS_EN: call pushes link 0x41, call pushes link 0x52, ret, ret -> redirects to 0x52 then 0x41; a 3rd ret -> redirect to 0x00 and ras_err_o=1.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the program counter of the 16-bit RISC core and drives the
// instruction-memory fetch handshake.  Each cycle the next PC is chosen from
// (highest priority first) a branch/jump redirect, a return-stack pop, a halt
// hold, or the sequential +1 adder.  The fetch address is held stable across
// memory wait states, fetches made stale by a redirect are squashed, and every
// accepted, non-squashed instruction is reported to decode one cycle later.
//
// Handshake: imem_req_o/pc_o form a request; a transfer happens in any cycle
// where imem_req_o & imem_ack_i.  Once imem_req_o is high it stays high, with
// pc_o unchanged, until that transfer happens (stall_i cannot withdraw it).
//
// Optional feature macro: PC_RAS_EN (return-address stack of RAS_DEPTH
// entries).  With it undefined, call_i / call_link_i / ret_i are ignored and
// ras_err_o is tied low.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   stall_i          decode back-pressure, blocks a new request
//   imem_req_o       fetch request to instruction memory
//   imem_ack_i       memory accepts the request this cycle
//   pc_o             current fetch address
//   redirect_i       branch/jump taken pulse
//   redirect_tgt_i   redirect target address
//   halt_i           stop-fetching pulse
//   resume_i         leave HALTED
//   fetch_valid_o    one-cycle pulse: instruction accepted and not squashed
//   fetch_pc_o       address of the instruction flagged by fetch_valid_o
//   halted_o         high in HALTED
//   call_i           call marker accompanying redirect_i (PC_RAS_EN)
//   call_link_i      return address to push (PC_RAS_EN)
//   ret_i            return pulse, redirects to stack top (PC_RAS_EN)
//   ras_err_o        sticky stack underflow/overflow flag (PC_RAS_EN)
//   dbg_state_o      FSM state for observation (0 BOOT, 1 FETCH, 2 HALTED)
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter int            AW        = 8,
   parameter logic [AW-1:0] RESET_PC  = '0,
   parameter int            RAS_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_i,
   output logic          imem_req_o,
   input  logic          imem_ack_i,
   output logic [AW-1:0] pc_o,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_tgt_i,
   input  logic          halt_i,
   input  logic          resume_i,
   output logic          fetch_valid_o,
   output logic [AW-1:0] fetch_pc_o,
   output logic          halted_o,
   input  logic          call_i,
   input  logic [AW-1:0] call_link_i,
   input  logic          ret_i,
   output logic          ras_err_o,
   output logic [1:0]    dbg_state_o
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          req_q, req_d;           // request raised earlier, not yet accepted
   logic          pend_q, pend_d;         // redirect arrived under an outstanding request
   logic [AW-1:0] pend_tgt_q, pend_tgt_d;
   logic          halt_pend_q, halt_pend_d;
   logic          fv_q, fv_d;
   logic [AW-1:0] fpc_q, fpc_d;

   logic          req;
   logic          accept;
   logic          redir_v;                // any PC redirect this cycle (branch or return)
   logic [AW-1:0] redir_tgt;

   // --------------------------------------------------------------------------
   // Return-address stack
   // --------------------------------------------------------------------------
`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [AW-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0] top_q;                  // index of the top entry when cnt_q > 0
   logic [PW:0]   cnt_q;
   logic          err_q;
   logic          ret_sel;
   logic          push;
   logic [PW-1:0] wr_idx;
   logic          ras_empty;
   logic          ras_full;

   // A branch outranks a return in the same cycle, so the return is dropped.
   assign ret_sel   = ret_i & ~redirect_i;
   assign push      = call_i & redirect_i;
   assign wr_idx    = top_q + 1'b1;
   assign ras_empty = (cnt_q == '0);
   assign ras_full  = (cnt_q == RAS_DEPTH[PW:0]);

   assign redir_v   = redirect_i | ret_sel;
   assign redir_tgt = redirect_i ? redirect_tgt_i :
                      (ras_empty ? RESET_PC : ras_q[top_q]);
   assign ras_err_o = err_q;

   // Circular buffer: pushing when full overwrites the oldest entry.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_q[wr_idx] <= call_link_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (push) begin
         top_q <= wr_idx;
         if (ras_full) begin
            err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (ret_sel) begin
         if (ras_empty) begin
            err_q <= 1'b1;
         end else begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end
`else
   logic unused_ras;

   assign unused_ras = ^{call_i, call_link_i, ret_i};
   assign redir_v    = redirect_i;
   assign redir_tgt  = redirect_tgt_i;
   assign ras_err_o  = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // FSM state and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         req_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         halt_pend_q <= 1'b0;
         fv_q        <= 1'b0;
         fpc_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_q       <= req_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
         halt_pend_q <= halt_pend_d;
         fv_q        <= fv_d;
         fpc_q       <= fpc_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state / next-PC logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_d       = 1'b0;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      halt_pend_d = halt_pend_q;
      fv_d        = 1'b0;
      fpc_d       = fpc_q;
      req         = 1'b0;
      accept      = 1'b0;

      case (state_q)
         ST_BOOT: begin
            state_d = halt_i ? ST_HALTED : ST_FETCH;
            if (redir_v) begin
               pc_d = redir_tgt;
            end
         end

         ST_FETCH: begin
            req    = req_q | ~stall_i;
            accept = req & imem_ack_i;
            if (accept) begin
               // A redirect now or one latched earlier makes this fetch stale.
               if (redir_v) begin
                  pc_d = redir_tgt;
               end else if (pend_q) begin
                  pc_d = pend_tgt_q;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
               if (!(redir_v | pend_q)) begin
                  fv_d  = 1'b1;
                  fpc_d = pc_q;
               end
               pend_d      = 1'b0;
               halt_pend_d = 1'b0;
               if (halt_i | halt_pend_q) begin
                  state_d = ST_HALTED;
               end
            end else if (req) begin
               // Request in flight: pc_o is frozen, so remember what arrived.
               req_d = 1'b1;
               if (redir_v) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
               if (halt_i) begin
                  halt_pend_d = 1'b1;
               end
            end else begin
               if (redir_v) begin
                  pc_d = redir_tgt;
               end
               if (halt_i) begin
                  state_d = ST_HALTED;
               end
            end
         end

         ST_HALTED: begin
            if (redir_v) begin
               pc_d = redir_tgt;
            end
            if (resume_i) begin
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign imem_req_o    = req;
   assign pc_o          = pc_q;
   assign fetch_valid_o = fv_q;
   assign fetch_pc_o    = fpc_q;
   assign halted_o      = (state_q == ST_HALTED);
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall_i;
   logic          imem_req_o;
   logic          imem_ack_i;
   logic [AW-1:0] pc_o;
   logic          redirect_i;
   logic [AW-1:0] redirect_tgt_i;
   logic          halt_i;
   logic          resume_i;
   logic          fetch_valid_o;
   logic [AW-1:0] fetch_pc_o;
   logic          halted_o;
   logic          call_i;
   logic [AW-1:0] call_link_i;
   logic          ret_i;
   logic          ras_err_o;
   logic [1:0]    dbg_state_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW-1:0] exp_q[$];

   pc_fetch_sequencer #(.AW(AW), .RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .imem_req_o     (imem_req_o),
      .imem_ack_i     (imem_ack_i),
      .pc_o           (pc_o),
      .redirect_i     (redirect_i),
      .redirect_tgt_i (redirect_tgt_i),
      .halt_i         (halt_i),
      .resume_i       (resume_i),
      .fetch_valid_o  (fetch_valid_o),
      .fetch_pc_o     (fetch_pc_o),
      .halted_o       (halted_o),
      .call_i         (call_i),
      .call_link_i    (call_link_i),
      .ret_i          (ret_i),
      .ras_err_o      (ras_err_o),
      .dbg_state_o    (dbg_state_o)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample #1 after the edge, and let the scoreboard
   // consume any delivered instruction.
   task automatic tick();
      logic [AW-1:0] e;
      @(posedge clk);
      #1;
      if (fetch_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_fetch", {31'd0, fetch_valid_o}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_fetch_pc", {24'd0, fetch_pc_o}, {24'd0, e});
         end
      end
   endtask

   // One accepted, non-squashed fetch at address p (ack must already be high).
   task automatic accept_cycle(input logic [AW-1:0] p);
      chk("acc_pc", {24'd0, pc_o}, {24'd0, p});
      chk("acc_req", {31'd0, imem_req_o}, 32'd1);
      exp_q.push_back(p);
      tick();
      chk("acc_valid", {31'd0, fetch_valid_o}, 32'd1);
   endtask

   task automatic redirect_pulse(input logic [AW-1:0] tgt);
      redirect_i     = 1'b1;
      redirect_tgt_i = tgt;
      tick();
      redirect_i     = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      stall_i        = 1'b0;
      imem_ack_i     = 1'b1;
      redirect_i     = 1'b0;
      redirect_tgt_i = '0;
      halt_i         = 1'b0;
      resume_i       = 1'b0;
      call_i         = 1'b0;
      call_link_i    = '0;
      ret_i          = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", {24'd0, pc_o}, 32'h00);
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_valid", {31'd0, fetch_valid_o}, 32'd0);
      chk("rst_fetch_pc", {24'd0, fetch_pc_o}, 32'h00);
      chk("rst_halted", {31'd0, halted_o}, 32'd0);
      chk("rst_ras_err", {31'd0, ras_err_o}, 32'd0);

      // BOOT lasts one cycle, then sequential fetch 00,01,...
      rst = 1'b1;
      #1;
      chk("boot_req", {31'd0, imem_req_o}, 32'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         accept_cycle(i[AW-1:0]);
      end

      // Redirect coinciding with accept squashes it; then wrap FE,FF,00,01
      redirect_pulse(8'hFE);
      chk("sq_same_cycle", {31'd0, fetch_valid_o}, 32'd0);
      chk("sq_pc", {24'd0, pc_o}, 32'hFE);
      accept_cycle(8'hFE);
      accept_cycle(8'hFF);
      accept_cycle(8'h00);
      accept_cycle(8'h01);

      // Wait states at 0x10 with stall toggling
      redirect_pulse(8'h10);
      chk("ws_sq", {31'd0, fetch_valid_o}, 32'd0);
      imem_ack_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         stall_i = k[0];
         #1;
         chk("ws_req", {31'd0, imem_req_o}, 32'd1);
         chk("ws_pc", {24'd0, pc_o}, 32'h10);
         tick();
         chk("ws_valid", {31'd0, fetch_valid_o}, 32'd0);
      end
      stall_i    = 1'b0;
      imem_ack_i = 1'b1;
      accept_cycle(8'h10);
      chk("ws_next_pc", {24'd0, pc_o}, 32'h11);

      // Redirect under an outstanding request at 0x20
      redirect_pulse(8'h20);
      chk("pend_sq0", {31'd0, fetch_valid_o}, 32'd0);
      imem_ack_i = 1'b0;
      #1;
      chk("pend_req", {31'd0, imem_req_o}, 32'd1);
      redirect_pulse(8'h80);
      chk("pend_hold_pc", {24'd0, pc_o}, 32'h20);
      chk("pend_hold_req", {31'd0, imem_req_o}, 32'd1);
      tick();
      chk("pend_hold_pc2", {24'd0, pc_o}, 32'h20);
      imem_ack_i = 1'b1;
      tick();
      chk("pend_squash", {31'd0, fetch_valid_o}, 32'd0);
      chk("pend_tgt_pc", {24'd0, pc_o}, 32'h80);
      accept_cycle(8'h80);

      // Halt while idle at 0x33
      stall_i = 1'b1;
      #1;
      chk("idle_req", {31'd0, imem_req_o}, 32'd0);
      redirect_pulse(8'h33);
      chk("idle_pc", {24'd0, pc_o}, 32'h33);
      halt_i = 1'b1;
      tick();
      halt_i  = 1'b0;
      stall_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("halt_halted", {31'd0, halted_o}, 32'd1);
         chk("halt_req", {31'd0, imem_req_o}, 32'd0);
         chk("halt_pc", {24'd0, pc_o}, 32'h33);
         tick();
         chk("halt_valid", {31'd0, fetch_valid_o}, 32'd0);
      end
      resume_i = 1'b1;
      tick();
      resume_i = 1'b0;
      chk("resume_halted", {31'd0, halted_o}, 32'd0);
      accept_cycle(8'h33);
      accept_cycle(8'h34);

      // Halt with an outstanding request: fetch completes, then HALTED
      imem_ack_i = 1'b0;
      halt_i     = 1'b1;
      tick();
      halt_i = 1'b0;
      chk("hp_halted0", {31'd0, halted_o}, 32'd0);
      chk("hp_req", {31'd0, imem_req_o}, 32'd1);
      chk("hp_pc", {24'd0, pc_o}, 32'h35);
      imem_ack_i = 1'b1;
      exp_q.push_back(8'h35);
      tick();
      chk("hp_delivered", {31'd0, fetch_valid_o}, 32'd1);
      chk("hp_halted1", {31'd0, halted_o}, 32'd1);
      chk("hp_req_off", {31'd0, imem_req_o}, 32'd0);
      chk("hp_next_pc", {24'd0, pc_o}, 32'h36);
      tick();
      chk("hp_no_more", {31'd0, fetch_valid_o}, 32'd0);
      resume_i = 1'b1;
      tick();
      resume_i = 1'b0;
      accept_cycle(8'h36);

`ifdef PC_RAS_EN
      // Return stack: two calls, two returns, then underflow
      call_i      = 1'b1;
      call_link_i = 8'h41;
      redirect_pulse(8'h60);
      call_link_i = 8'h52;
      redirect_pulse(8'h70);
      call_i = 1'b0;
      chk("ras_call_pc", {24'd0, pc_o}, 32'h70);
      ret_i = 1'b1;
      tick();
      chk("ras_ret1", {24'd0, pc_o}, 32'h52);
      tick();
      chk("ras_ret2", {24'd0, pc_o}, 32'h41);
      chk("ras_err0", {31'd0, ras_err_o}, 32'd0);
      tick();
      ret_i = 1'b0;
      chk("ras_ret3", {24'd0, pc_o}, 32'h00);
      chk("ras_err1", {31'd0, ras_err_o}, 32'd1);
      chk("ras_sq", {31'd0, fetch_valid_o}, 32'd0);
      accept_cycle(8'h00);
`else
      // Without the stack, return pulses are ignored
      ret_i = 1'b1;
      accept_cycle(8'h37);
      ret_i = 1'b0;
      chk("noras_err", {31'd0, ras_err_o}, 32'd0);
      chk("noras_pc", {24'd0, pc_o}, 32'h38);
`endif

      // Nothing expected may remain undelivered
      imem_ack_i = 1'b0;
      tick();
      chk("sb_drain", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
